// File: rtl/vending_fsm_param.sv
// Parametrised vending-machine controller: coin credit accumulator, price check,
// one-cycle vend pulse and greedy change return over a valid/ready handshake.
module vending_fsm_param #(
  parameter int unsigned N_PROD   = 4,
  parameter int unsigned CREDIT_W = 8,
  // Product i occupies slice i, so product 0 (20) sits in the low byte
  parameter logic [N_PROD*CREDIT_W-1:0] PRICES    = {8'd75, 8'd50, 8'd35, 8'd20},
  parameter logic [4*CREDIT_W-1:0]      COIN_VALS = {8'd100, 8'd25, 8'd10, 8'd5},
  parameter int unsigned MAX_CREDIT = 200,
  localparam int unsigned SW = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                sel_valid,
  input  logic [SW-1:0]       sel_idx,
  input  logic                cancel,
  input  logic                chg_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                vend_valid,
  output logic [SW-1:0]       vend_idx,
  output logic                sel_err,
  output logic                chg_valid,
  output logic [1:0]          chg_type,
  output logic                busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_VEND, S_CHANGE} state_t;

  localparam logic [CREDIT_W:0] MAXC = (CREDIT_W+1)'(MAX_CREDIT);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                coin_reject_q, coin_reject_d;
  logic                vend_valid_q, vend_valid_d;
  logic [SW-1:0]       vend_idx_q, vend_idx_d;
  logic                sel_err_q, sel_err_d;
  logic                chg_valid_q, chg_valid_d;
  logic [1:0]          chg_type_q, chg_type_d;
  logic                busy_q, busy_d;

  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] t);
    return COIN_VALS[t*CREDIT_W +: CREDIT_W];
  endfunction

  function automatic logic [CREDIT_W-1:0] price_of(input logic [SW-1:0] idx);
    logic [CREDIT_W-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < N_PROD; i++)
      if (idx == i[SW-1:0]) p = PRICES[i*CREDIT_W +: CREDIT_W];
    return p;
  endfunction

  // Coin values ascend with index, so the last fitting index is the largest coin
  function automatic logic [1:0] greedy(input logic [CREDIT_W-1:0] c);
    logic [1:0] g;
    g = '0;
    for (int unsigned k = 0; k < 4; k++)
      if (coin_value(k[1:0]) <= c) g = k[1:0];
    return g;
  endfunction

  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] price;
  logic                sel_bad;
  logic                go_chg;
  logic [CREDIT_W-1:0] rem;

  assign sum     = {1'b0, credit_q} + {1'b0, coin_value(coin_type)};
  assign price   = price_of(sel_idx);
  assign sel_bad = ({1'b0, sel_idx} >= (SW+1)'(N_PROD)) || (credit_q < price);

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    coin_reject_d = 1'b0;
    vend_valid_d  = 1'b0;
    vend_idx_d    = vend_idx_q;
    sel_err_d     = 1'b0;
    chg_valid_d   = 1'b0;
    chg_type_d    = chg_type_q;
    go_chg        = 1'b0;
    rem           = credit_q;

    unique case (state_q)
      S_IDLE, S_ACCUM: begin
        if (cancel) begin
          coin_reject_d = coin_valid;
          go_chg        = (credit_q != '0);
        end else if (sel_valid) begin
          coin_reject_d = coin_valid;
          if (sel_bad) begin
            sel_err_d = 1'b1;
          end else begin
            state_d      = S_VEND;
            vend_valid_d = 1'b1;
            vend_idx_d   = sel_idx;
            credit_d     = credit_q - price;
          end
        end else if (coin_valid) begin
          if (sum <= MAXC) begin
            credit_d = sum[CREDIT_W-1:0];
            state_d  = S_ACCUM;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end
      S_VEND: begin
        coin_reject_d = coin_valid;
        go_chg        = 1'b1;
      end
      S_CHANGE: begin
        coin_reject_d = coin_valid;
        if (chg_valid_q && chg_ready) begin
          go_chg = 1'b1;
          rem    = credit_q - coin_value(chg_type_q);
        end else begin
          chg_valid_d = chg_valid_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Shared exit path for VEND, cancel and each change handshake
    if (go_chg) begin
      credit_d = rem;
      if (rem == '0) begin
        state_d = S_IDLE;
      end else if (rem < coin_value(2'd0)) begin
        credit_d = '0;
        state_d  = S_IDLE;
      end else begin
        state_d     = S_CHANGE;
        chg_valid_d = 1'b1;
        chg_type_d  = greedy(rem);
      end
    end

    busy_d = (state_d == S_VEND) || (state_d == S_CHANGE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      credit_q      <= '0;
      coin_reject_q <= 1'b0;
      vend_valid_q  <= 1'b0;
      vend_idx_q    <= '0;
      sel_err_q     <= 1'b0;
      chg_valid_q   <= 1'b0;
      chg_type_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      coin_reject_q <= coin_reject_d;
      vend_valid_q  <= vend_valid_d;
      vend_idx_q    <= vend_idx_d;
      sel_err_q     <= sel_err_d;
      chg_valid_q   <= chg_valid_d;
      chg_type_q    <= chg_type_d;
      busy_q        <= busy_d;
    end
  end

  assign credit      = credit_q;
  assign coin_reject = coin_reject_q;
  assign vend_valid  = vend_valid_q;
  assign vend_idx    = vend_idx_q;
  assign sel_err     = sel_err_q;
  assign chg_valid   = chg_valid_q;
  assign chg_type    = chg_type_q;
  assign busy        = busy_q;

endmodule
